// File: rtl/oled_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | oled_pkg : FSM states, command opcodes and control-byte fields           |
// | Rev 1.0  : initial release                                               |
// +--------------------------------------------------------------------------+
package oled_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    CTRL     = 3'd3,
    CTRL_ACK = 3'd4,
    BYTE     = 3'd5,
    BYTE_ACK = 3'd6,
    IGNORE   = 3'd7
  } state_t;

  localparam logic [6:0] OLED_DEFAULT_ADDR = 7'h3C;

  localparam logic [7:0] CMD_COL_LO      = 8'h00;
  localparam logic [7:0] CMD_COL_HI      = 8'h10;
  localparam logic [7:0] CMD_PAGE_BASE   = 8'hB0;
  localparam logic [7:0] CMD_DISP_OFF    = 8'hAE;
  localparam logic [7:0] CMD_DISP_ON     = 8'hAF;
  localparam logic [7:0] CMD_MEM_MODE    = 8'h20;
  localparam logic [7:0] CMD_CONTRAST    = 8'h81;
  localparam logic [7:0] CMD_CHARGE_PUMP = 8'h8D;
  localparam logic [7:0] CMD_MUX_RATIO   = 8'hA8;
  localparam logic [7:0] CMD_DISP_OFFSET = 8'hD3;
  localparam logic [7:0] CMD_CLK_DIV     = 8'hD5;
  localparam logic [7:0] CMD_PRECHARGE   = 8'hD9;
  localparam logic [7:0] CMD_COM_PINS    = 8'hDA;
  localparam logic [7:0] CMD_VCOMH       = 8'hDB;

  localparam int CTRL_CO_BIT = 7;
  localparam int CTRL_DC_BIT = 6;

  // Opcodes whose following command byte is a parameter, not a new command
  function automatic logic takes_arg(input logic [7:0] op);
    return op inside {CMD_MEM_MODE, CMD_CONTRAST, CMD_CHARGE_PUMP, CMD_MUX_RATIO,
                      CMD_DISP_OFFSET, CMD_CLK_DIV, CMD_PRECHARGE, CMD_COM_PINS,
                      CMD_VCOMH};
  endfunction

endpackage
`default_nettype wire

// File: rtl/oled_i2c_target_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | oled_i2c_target_if : I2C pins plus received-byte stream of the target    |
// | Rev 1.0  : initial release                                               |
// +--------------------------------------------------------------------------+
interface oled_i2c_target_if;
  logic       scl;
  logic       sda_i;
  logic       sda_oe;
  logic       byte_valid;
  logic       byte_dc;
  logic [7:0] byte_data;
  logic [2:0] page;
  logic [6:0] col;
  logic       disp_on;

  modport slave (
    input  scl, sda_i,
    output sda_oe, byte_valid, byte_dc, byte_data, page, col, disp_on
  );

  modport master (
    output scl, sda_i,
    input  sda_oe, byte_valid, byte_dc, byte_data, page, col, disp_on
  );
endinterface
`default_nettype wire

// File: rtl/i2c_line_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2c_line_sync : SCL/SDA synchroniser, optional level filter              |
// | (OLED_I2C_TGT_GLITCH_FILTER_EN), START/STOP and SCL edge detection       |
// | Rev 1.0  : initial release                                               |
// +--------------------------------------------------------------------------+
module i2c_line_sync #(
  parameter int MIN_SCL_CLKS = 4
) (
  input  wire  clk,
  input  wire  rst,
  input  wire  scl,
  input  wire  sda,
  output logic sda_lvl,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_sync_q, scl_sync_d;
  logic [1:0] sda_sync_q, sda_sync_d;
  logic       scl_prev_q, scl_prev_d;
  logic       sda_prev_q, sda_prev_d;
  logic       scl_lvl;

  always_comb begin
    scl_sync_d = {scl_sync_q[0], scl};
    sda_sync_d = {sda_sync_q[0], sda};
    scl_prev_d = scl_lvl;
    sda_prev_d = sda_lvl;
  end

  // Synchronisers reset to 1 so an idle bus produces no false edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

`ifdef OLED_I2C_TGT_GLITCH_FILTER_EN
  localparam int CW = $clog2(MIN_SCL_CLKS + 1);

  logic          scl_flt_q, scl_flt_d;
  logic          sda_flt_q, sda_flt_d;
  logic [CW-1:0] scl_cnt_q, scl_cnt_d;
  logic [CW-1:0] sda_cnt_q, sda_cnt_d;

  // A new level is taken only after MIN_SCL_CLKS consecutive differing samples
  always_comb begin
    scl_flt_d = scl_flt_q;
    sda_flt_d = sda_flt_q;
    scl_cnt_d = '0;
    sda_cnt_d = '0;
    if (scl_sync_q[1] != scl_flt_q) begin
      if (scl_cnt_q == CW'(MIN_SCL_CLKS - 1)) scl_flt_d = scl_sync_q[1];
      else                                   scl_cnt_d = scl_cnt_q + 1'b1;
    end
    if (sda_sync_q[1] != sda_flt_q) begin
      if (sda_cnt_q == CW'(MIN_SCL_CLKS - 1)) sda_flt_d = sda_sync_q[1];
      else                                   sda_cnt_d = sda_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_flt_q <= 1'b1;
      sda_flt_q <= 1'b1;
      scl_cnt_q <= '0;
      sda_cnt_q <= '0;
    end else begin
      scl_flt_q <= scl_flt_d;
      sda_flt_q <= sda_flt_d;
      scl_cnt_q <= scl_cnt_d;
      sda_cnt_q <= sda_cnt_d;
    end
  end

  assign scl_lvl = scl_flt_q;
  assign sda_lvl = sda_flt_q;
`else
  assign scl_lvl = scl_sync_q[1];
  assign sda_lvl = sda_sync_q[1];
`endif

  assign scl_rise  =  scl_lvl & ~scl_prev_q;
  assign scl_fall  = ~scl_lvl &  scl_prev_q;
  assign start_det =  scl_lvl &  scl_prev_q &  sda_prev_q & ~sda_lvl;
  assign stop_det  =  scl_lvl &  scl_prev_q & ~sda_prev_q &  sda_lvl;

endmodule
`default_nettype wire

// File: rtl/oled_i2c_target.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | oled_i2c_target : write-only I2C target for an OLED controller, emits    |
// | command/data bytes and tracks page/column/display-on state               |
// | Rev 1.0  : initial release                                               |
// +--------------------------------------------------------------------------+
module oled_i2c_target
  import oled_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR     = OLED_DEFAULT_ADDR,
  parameter int         MIN_SCL_CLKS = 4
) (
  input wire clk,
  input wire rst,
  oled_i2c_target_if.slave bus
);

  logic sda_lvl, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_sync #(.MIN_SCL_CLKS(MIN_SCL_CLKS)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl       (bus.scl),
    .sda       (bus.sda_i),
    .sda_lvl   (sda_lvl),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       sda_oe_q, sda_oe_d;
  logic       co_q, co_d, dc_q, dc_d, arg_q, arg_d;
  logic       byte_valid_q, byte_valid_d, byte_dc_q, byte_dc_d;
  logic [7:0] byte_data_q, byte_data_d;
  logic [2:0] page_q, page_d;
  logic [6:0] col_q, col_d;
  logic       disp_on_q, disp_on_d;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    sda_oe_d     = sda_oe_q;
    co_d         = co_q;
    dc_d         = dc_q;
    arg_d        = arg_q;
    byte_valid_d = 1'b0;
    byte_dc_d    = byte_dc_q;
    byte_data_d  = byte_data_q;
    page_d       = page_q;
    col_d        = col_q;
    disp_on_d    = disp_on_q;

    // Pointer/decode side effects land the cycle after the byte is presented
    if (byte_valid_q) begin
      if (byte_dc_q)  col_d = col_q + 7'd1;
      else if (arg_q) arg_d = 1'b0;
      else begin
        arg_d = takes_arg(byte_data_q);
        if (byte_data_q[7:3] == CMD_PAGE_BASE[7:3]) page_d     = byte_data_q[2:0];
        if (byte_data_q[7:4] == CMD_COL_LO[7:4])    col_d[3:0] = byte_data_q[3:0];
        if (byte_data_q[7:3] == CMD_COL_HI[7:3])    col_d[6:4] = byte_data_q[2:0];
        if (byte_data_q == CMD_DISP_ON)             disp_on_d  = 1'b1;
        if (byte_data_q == CMD_DISP_OFF)            disp_on_d  = 1'b0;
      end
    end

    if (stop_det) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      shift_d   = '0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        ADDR, CTRL, BYTE: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            shift_d   = {shift_q[6:0], sda_lvl};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (state_q == BYTE && bit_cnt_q == 4'd7) begin
              byte_valid_d = 1'b1;
              byte_data_d  = {shift_q[6:0], sda_lvl};
              byte_dc_d    = dc_q;
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = '0;
            sda_oe_d  = 1'b1;
            if (state_q == ADDR) begin
              if (shift_q == {DEV_ADDR, 1'b0}) state_d = ADDR_ACK;
              else begin
                state_d  = IGNORE;
                sda_oe_d = 1'b0;
              end
            end else if (state_q == CTRL) begin
              co_d    = shift_q[CTRL_CO_BIT];
              dc_d    = shift_q[CTRL_DC_BIT];
              state_d = CTRL_ACK;
            end else begin
              state_d = BYTE_ACK;
            end
          end
        end
        ADDR_ACK, CTRL_ACK, BYTE_ACK: begin
          // The next falling edge ends the 9th clock
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            if (state_q == ADDR_ACK)      state_d = CTRL;
            else if (state_q == CTRL_ACK) state_d = BYTE;
            else                          state_d = co_q ? CTRL : BYTE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      sda_oe_q     <= 1'b0;
      co_q         <= 1'b0;
      dc_q         <= 1'b0;
      arg_q        <= 1'b0;
      byte_valid_q <= 1'b0;
      byte_dc_q    <= 1'b0;
      byte_data_q  <= '0;
      page_q       <= '0;
      col_q        <= '0;
      disp_on_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      sda_oe_q     <= sda_oe_d;
      co_q         <= co_d;
      dc_q         <= dc_d;
      arg_q        <= arg_d;
      byte_valid_q <= byte_valid_d;
      byte_dc_q    <= byte_dc_d;
      byte_data_q  <= byte_data_d;
      page_q       <= page_d;
      col_q        <= col_d;
      disp_on_q    <= disp_on_d;
    end
  end

  assign bus.sda_oe     = sda_oe_q;
  assign bus.byte_valid = byte_valid_q;
  assign bus.byte_dc    = byte_dc_q;
  assign bus.byte_data  = byte_data_q;
  assign bus.page       = page_q;
  assign bus.col        = col_q;
  assign bus.disp_on    = disp_on_q;

endmodule
`default_nettype wire

// File: tb/tb_oled_i2c_target.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_oled_i2c_target : bit-banged I2C master, byte scoreboard, OLED model  |
// | Rev 1.0  : initial release                                               |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_oled_i2c_target;

  typedef logic [7:0] bytes_t[$];
  typedef struct packed {
    logic       dc;
    logic [7:0] data;
    logic [2:0] page;
    logic [6:0] col;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  always #5 clk = ~clk;

  oled_i2c_target_if bus ();
  assign bus.scl   = scl_m;
  assign bus.sda_i = sda_m & ~bus.sda_oe;

  oled_i2c_target #(.DEV_ADDR(7'h3C), .MIN_SCL_CLKS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  bytes_t txq;

  // Reference model of the display controller state
  int m_page = 0, m_col = 0;
  bit m_disp = 0, m_arg = 0;

  logic [7:0] arg_ops [9] = '{8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB};
  logic [7:0] cmd_pool[14] = '{8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9,
                               8'hDA, 8'hDB, 8'hAE, 8'hAF, 8'hB5, 8'h0A, 8'h13};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic bit is_arg_op(input logic [7:0] b);
    foreach (arg_ops[i]) if (arg_ops[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_page = 0; m_col = 0; m_disp = 0; m_arg = 0;
    sb_q.delete();
  endtask

  task automatic model_payload(input bit dc, input logic [7:0] b);
    exp_t e;
    e.dc = dc; e.data = b; e.page = 3'(m_page); e.col = 7'(m_col);
    sb_q.push_back(e);
    if (dc) m_col = (m_col + 1) % 128;
    else if (m_arg) m_arg = 0;
    else begin
      if (b >= 8'hB0 && b <= 8'hB7) m_page = b - 8'hB0;
      if (b <= 8'h0F) m_col = (m_col / 16) * 16 + b;
      if (b >= 8'h10 && b <= 8'h17) m_col = (m_col % 16) + (b - 8'h10) * 16;
      if (b == 8'hAF) m_disp = 1;
      if (b == 8'hAE) m_disp = 0;
      m_arg = is_arg_op(b);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.byte_valid === 1'b1) begin
      if (sb_q.size() == 0) check("unexpected_byte_valid", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb_q.pop_front();
        check("byte{dc,data,page,col}", {bus.byte_dc, bus.byte_data, bus.page, bus.col}, 32'(e));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_bit(input bit b);
    sda_m = b; tick(4);
    scl_m = 1'b1; tick(6);
    @(negedge clk) check("oe_during_data_bit", 32'(bus.sda_oe), 32'd0);
    tick(2);
    scl_m = 1'b0; tick(4);
  endtask

  task automatic ack_bit(input bit exp_ack);
    sda_m = 1'b1; tick(4);
    scl_m = 1'b1; tick(6);
    @(negedge clk) check(exp_ack ? "ack_expected" : "nack_expected", 32'(bus.sda_oe), 32'(exp_ack));
    tick(2);
    scl_m = 1'b0; tick(4);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit exp_ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    ack_bit(exp_ack);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(4);
    scl_m = 1'b1; tick(8);
    sda_m = 1'b0; tick(8);
    scl_m = 1'b0; tick(4);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(4);
    scl_m = 1'b1; tick(8);
    sda_m = 1'b1; tick(8);
  endtask

  // Drives one write transaction and predicts ACKs and emitted bytes
  task automatic write_txn(input bytes_t bs, input bit do_stop);
    bit addr_ok, need_ctrl, co, dc, exp_ack;
    addr_ok = 0; need_ctrl = 1; co = 0; dc = 0;
    i2c_start();
    foreach (bs[i]) begin
      if (i == 0) begin
        addr_ok = (bs[0] == 8'h78);
        exp_ack = addr_ok;
      end else if (!addr_ok) exp_ack = 0;
      else begin
        exp_ack = 1;
        if (need_ctrl) begin
          co = bs[i][7]; dc = bs[i][6]; need_ctrl = 0;
        end else begin
          model_payload(dc, bs[i]);
          need_ctrl = co;
        end
      end
      send_byte(bs[i], exp_ack);
    end
    if (do_stop) i2c_stop();
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(3);
    rst = 1'b0; tick(2);
    model_reset();
  endtask

  task automatic check_state(input string nm);
    tick(4);
    check({nm, "_page"}, 32'(bus.page), 32'(m_page));
    check({nm, "_col"}, 32'(bus.col), 32'(m_col));
    check({nm, "_disp_on"}, 32'(bus.disp_on), 32'(m_disp));
    check({nm, "_sb_drained"}, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] b;
    int n, r;
    tick(4);
    @(negedge clk);
    check("rst_sda_oe", 32'(bus.sda_oe), 0);
    check("rst_byte_valid", 32'(bus.byte_valid), 0);
    check("rst_byte_dc", 32'(bus.byte_dc), 0);
    check("rst_byte_data", 32'(bus.byte_data), 0);
    check("rst_page", 32'(bus.page), 0);
    check("rst_col", 32'(bus.col), 0);
    check("rst_disp_on", 32'(bus.disp_on), 0);
    rst = 1'b0; tick(4);

    // Argument byte after 8D must not move the column
    txq = {8'h78, 8'h00, 8'h8D, 8'h14};
    write_txn(txq, 1);
    check_state("charge_pump_arg");

    txq = {8'h78, 8'h00, 8'hAF, 8'hA6};
    write_txn(txq, 1);
    check_state("disp_on_cmds");

    txq = {8'h78, 8'h00, 8'hB3, 8'h05, 8'h12};
    write_txn(txq, 1);
    txq = {8'h78, 8'h40, 8'h11, 8'h22};
    write_txn(txq, 1);
    check_state("page3_col37");

    txq = {8'h7A, 8'h00, 8'hAE};
    write_txn(txq, 1);
    txq = {8'h79, 8'h00, 8'hAE};
    write_txn(txq, 1);
    check_state("bad_addr");

    txq = {8'h78, 8'h00, 8'h0F, 8'h17};
    write_txn(txq, 1);
    txq = {8'h78, 8'h40, 8'hFF, 8'h01};
    write_txn(txq, 1);
    check_state("col_wrap");

    // Co=1 control bytes alternate with single payload bytes
    txq = {8'h78, 8'h80, 8'hB6, 8'hC0, 8'h5A, 8'h00, 8'hAE, 8'h03};
    write_txn(txq, 1);
    check_state("co_single");

    // START after 5 bits of a payload byte drops the byte
    i2c_start();
    send_byte(8'h78, 1);
    send_byte(8'h40, 1);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    txq = {8'h78, 8'h40, 8'h33};
    write_txn(txq, 1);
    check_state("abort_start");

    // Reset in the middle of the address ACK releases SDA
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(i == 0 ? 1'b0 : (8'h78 >> i) & 1'b1);
    sda_m = 1'b1; tick(4);
    scl_m = 1'b1; tick(4);
    @(negedge clk) check("ack_before_rst", 32'(bus.sda_oe), 1);
    rst = 1'b1;
    @(negedge clk) check("rst_mid_ack_release", 32'(bus.sda_oe), 0);
    tick(2);
    rst = 1'b0;
    model_reset();
    scl_m = 1'b0; tick(4);
    i2c_stop();
    check_state("after_rst");

    for (int t = 0; t < 25; t++) begin
      txq = {};
      txq.push_back(($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h78);
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        r = $urandom_range(0, 3);
        case (r)
          0:       b = 8'($urandom_range(0, 3) << 6);
          1:       b = cmd_pool[$urandom_range(0, 13)];
          2:       b = 8'($urandom);
          default: b = ($urandom_range(0, 1) != 0) ? 8'(8'hB0 + $urandom_range(0, 7))
                                                   : 8'($urandom_range(0, 23));
        endcase
        txq.push_back(b);
      end
      write_txn(txq, ($urandom_range(0, 2) != 0));
    end
    i2c_stop();
    check_state("random_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
